pulse_status_tx: RTL

UART readback transmitter that returns the active pulse-sequence configuration to the host PC. On a request it snapshots the parameter set held by the control decoder and serializes it as one framed, optionally checksummed, 8N1 byte stream on the RS232 transmit pin. It is the transmit end of the same host link that the control receiver decodes, and lets the host confirm exactly which values the pulse generator is running.

---
 rtl/pulse_status_pkg.sv | 29 ++
 rtl/pulse_status_tx_uart.sv | 54 +++++
 rtl/pulse_status_tx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pulse_status_pkg.sv
// Shared constants, frame-state type and payload byte selector for the pulse status readback link.
// Optional checksum byte is enabled by defining PULSE_STATUS_CHECKSUM_EN.
package pulse_status_pkg;

    localparam logic [7:0] HEADER_BYTE   = 8'hA5;
    localparam int         PAYLOAD_BYTES = 24;
    localparam int         PAYLOAD_BITS  = PAYLOAD_BYTES * 8;

    localparam int FLAG_CP_BIT = 0;
    localparam int FLAG_BL_BIT = 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FINISH
    } frame_state_t;

    // Index 1 is the first byte after the header, taken from the MSB end of the snapshot.
    function automatic logic [7:0] payload_byte(input logic [PAYLOAD_BITS-1:0] payload,
                                                input logic [4:0]              index);
        logic [7:0] value;
        value = '0;
        if (index != 5'd0 && int'(index) <= PAYLOAD_BYTES) begin
            value = payload[(PAYLOAD_BYTES - int'(index)) * 8 +: 8];
        end
        return value;
    endfunction

endpackage

// File: rtl/pulse_status_tx_uart.sv
// 8N1 byte serializer (module uart_tx_byte): start bit, 8 data bits LSB first, stop bit.
// A new byte may be loaded on the last stop-bit cycle, giving gap-free back-to-back bytes.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic          active;
    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_idx;
    logic [9:0]    shreg;
    logic          bit_end;
    logic          last_tick;

    assign bit_end   = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign last_tick = active && bit_end && (bit_idx == 4'd9);
    assign ready     = !active || last_tick;
    assign tx        = active ? shreg[0] : 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active  <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '1;
        end else if (start && ready) begin
            active  <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= {1'b1, data, 1'b0};
        end else if (active) begin
            if (bit_end) begin
                clk_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    shreg   <= {1'b1, shreg[9:1]};
                end
            end else begin
                clk_cnt <= clk_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pulse_status_tx.sv
// Pulse-sequence status readback: snapshots the parameter set on req and sends it as one UART frame.
// Define PULSE_STATUS_CHECKSUM_EN to append a mod-256 payload checksum byte.
module pulse_status_tx #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic [31:0] per,
    input  logic [15:0] p1wid,
    input  logic [15:0] del,
    input  logic [15:0] p2wid,
    input  logic [15:0] p1wid2,
    input  logic [15:0] del2,
    input  logic [15:0] p2wid2,
    input  logic [15:0] p1st2,
    input  logic [15:0] nut_d,
    input  logic [7:0]  nut_w,
    input  logic [6:0]  pr_att,
    input  logic [7:0]  p_bl,
    input  logic        cp,
    input  logic        bl,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    import pulse_status_pkg::*;

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
`ifdef PULSE_STATUS_CHECKSUM_EN
    localparam int FRAME_BYTES = PAYLOAD_BYTES + 2;
`else
    localparam int FRAME_BYTES = PAYLOAD_BYTES + 1;
`endif
    localparam logic [4:0] LAST_INDEX = 5'(FRAME_BYTES - 1);

    frame_state_t            state;
    frame_state_t            state_next;
    logic [PAYLOAD_BITS-1:0] snapshot;
    logic [4:0]              index;
    logic [7:0]              flags;
    logic [7:0]              next_byte;
    logic                    accept;
    logic                    advance;
    logic                    ser_start;
    logic                    ser_ready;
    logic [7:0]              ser_data;

    // The done cycle also accepts, so a held req restarts with a single idle cycle.
    assign accept  = (state == IDLE || state == FINISH) && req;
    assign advance = (state == SEND) && ser_ready && (index != LAST_INDEX);

    always_comb begin
        flags              = '0;
        flags[FLAG_CP_BIT] = cp;
        flags[FLAG_BL_BIT] = bl;
    end

`ifdef PULSE_STATUS_CHECKSUM_EN
    logic [7:0] checksum;

    assign next_byte = (index == 5'(PAYLOAD_BYTES)) ? checksum
                                                    : payload_byte(snapshot, index + 5'd1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (advance && index < 5'(PAYLOAD_BYTES)) begin
            checksum <= checksum + next_byte;
        end
    end
`else
    assign next_byte = payload_byte(snapshot, index + 5'd1);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            snapshot <= '0;
            index    <= '0;
        end else if (accept) begin
            snapshot <= {per, p1wid, del, p2wid, p1wid2, del2, p2wid2, p1st2, nut_d,
                         nut_w, 1'b0, pr_att, p_bl, flags};
            index    <= '0;
        end else if (advance) begin
            index <= index + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = SEND;
            SEND:    if (ser_ready && index == LAST_INDEX) state_next = FINISH;
            FINISH:  state_next = req ? SEND : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == SEND);
        done      = (state == FINISH);
        ser_start = accept || advance;
        ser_data  = accept ? HEADER_BYTE : next_byte;
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk   (clk),
        .resetn(resetn),
        .start (ser_start),
        .data  (ser_data),
        .tx    (tx),
        .ready (ser_ready)
    );

endmodule
